tinyqv_instr_align: RTL and testbench

Instruction alignment buffer sitting directly upstream of the TinyQV decoder. Accepts a sequential stream of 16-bit halfwords from the instruction memory interface, stores them in a small circular queue, and presents a 32-bit window whose low halfword is the next instruction, with its PC. Pops one halfword for a compressed instruction or two for a 32-bit instruction, and restarts fetch on a flush such as a taken branch, jump or trap.

---
 rtl/tinyqv_instr_align.sv | 112 +++++++++++
 tb/tb_tinyqv_instr_align.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tinyqv_instr_align.sv
// Instruction alignment queue between the halfword fetch stream and the TinyQV decoder.
// Optional same-cycle bypass of incoming halfwords: define TINYQV_INSTR_BYPASS_EN.
module tinyqv_instr_align #(
    parameter int DEPTH_HW  = 4,
    parameter int ADDR_BITS = 24
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [15:0]                 mem_data,
    input  logic                        mem_valid,
    output logic                        mem_ready,
    input  logic                        flush,
    input  logic [ADDR_BITS-1:0]        flush_addr,
    output logic                        fetch_restart,
    output logic [ADDR_BITS-1:0]        fetch_addr,
    output logic [31:0]                 instr,
    output logic                        instr_valid,
    output logic [ADDR_BITS-1:0]        instr_pc,
    input  logic                        instr_accept,
    output logic [$clog2(DEPTH_HW):0]   hw_count
);

    localparam int PW = $clog2(DEPTH_HW);
    localparam int CW = PW + 1;

    logic [15:0]          mem_q [DEPTH_HW];
    logic [15:0]          mem_d [DEPTH_HW];
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [ADDR_BITS-1:0] pc_q, pc_d;

    logic                 push;
    logic                 byp_used;
    logic                 wr_en;
    logic [CW-1:0]        avail;
    logic [15:0]          slot0, slot1, lo, hi;
    logic                 is32;
    logic [1:0]           n_pop;
    logic [PW-1:0]        rd_adv;
    logic                 unused_addr_lsb;

    assign unused_addr_lsb = flush_addr[0];
    assign fetch_restart   = flush;
    assign fetch_addr      = {flush_addr[ADDR_BITS-1:1], 1'b0};
    assign mem_ready       = (count_q < CW'(DEPTH_HW)) && !flush;
    assign push            = mem_valid && mem_ready;
    assign hw_count        = count_q;
    assign instr_pc        = pc_q;

    always_comb begin
`ifdef TINYQV_INSTR_BYPASS_EN
        // Incoming halfword fills whichever window slot the queue cannot.
        avail = count_q + CW'(push);
        slot0 = (count_q != '0) ? mem_q[rd_ptr_q] : mem_data;
        slot1 = (count_q >= CW'(2)) ? mem_q[rd_ptr_q + PW'(1)] : mem_data;
`else
        avail = count_q;
        slot0 = mem_q[rd_ptr_q];
        slot1 = mem_q[rd_ptr_q + PW'(1)];
`endif
        lo          = (avail >= CW'(1)) ? slot0 : '0;
        hi          = (avail >= CW'(2)) ? slot1 : '0;
        instr       = {hi, lo};
        is32        = (lo[1:0] == 2'b11);
        instr_valid = (avail >= CW'(1)) && (!is32 || (avail >= CW'(2)));
    end

    always_comb begin
        n_pop = 2'd0;
        if (instr_accept && instr_valid && !flush)
            n_pop = is32 ? 2'd2 : 2'd1;

        // A pushed halfword consumed in the same cycle is never stored.
        byp_used = push && (CW'(n_pop) > count_q);
        wr_en    = push && !byp_used;
        rd_adv   = byp_used ? count_q[PW-1:0] : PW'(n_pop);

        mem_d = mem_q;
        if (wr_en)
            mem_d[wr_ptr_q] = mem_data;

        rd_ptr_d = rd_ptr_q + rd_adv;
        wr_ptr_d = wr_ptr_q + PW'(wr_en);
        count_d  = count_q + CW'(push) - CW'(n_pop);
        pc_d     = pc_q + ADDR_BITS'({n_pop, 1'b0});

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pc_d     = fetch_addr;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
        end
    end

endmodule

// File: tb/tb_tinyqv_instr_align.sv
// Directed bench for tinyqv_instr_align with hand-computed expectations.
module tb_tinyqv_instr_align;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] mem_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic        flush = 1'b0;
    logic [23:0] flush_addr = '0;
    logic        fetch_restart;
    logic [23:0] fetch_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [23:0] instr_pc;
    logic        instr_accept = 1'b0;
    logic [2:0]  hw_count;

    int vectors = 0;
    int miscompares = 0;

    tinyqv_instr_align #(.DEPTH_HW(4), .ADDR_BITS(24)) dut (
        .clk(clk), .rstn(rstn),
        .mem_data(mem_data), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .flush(flush), .flush_addr(flush_addr),
        .fetch_restart(fetch_restart), .fetch_addr(fetch_addr),
        .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc),
        .instr_accept(instr_accept), .hw_count(hw_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [15:0] md, input logic acc);
        mem_valid    = mv;
        mem_data     = md;
        instr_accept = acc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_valid    = 1'b0;
        instr_accept = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic step(input logic mv, input logic [15:0] md, input logic acc);
        drive(mv, md, acc);
        tick();
    endtask

    initial begin
        #12;
        chk("rst_count", 32'(hw_count), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        chk("rst_ready", 32'(mem_ready), 32'd1);
        chk("rst_restart", 32'(fetch_restart), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // 16-bit instruction into an empty queue
        drive(1'b1, 16'h4501, 1'b0);
`ifndef TINYQV_INSTR_BYPASS_EN
        #1 chk("c16_same_cycle_valid", 32'(instr_valid), 32'd0);
`endif
        tick();
        chk("c16_valid", 32'(instr_valid), 32'd1);
        chk("c16_instr", instr, 32'h0000_4501);
        chk("c16_pc", 32'(instr_pc), 32'h0);
        step(1'b0, 16'h0, 1'b1);
        chk("c16_pop_count", 32'(hw_count), 32'd0);
        chk("c16_pop_pc", 32'(instr_pc), 32'h2);
        chk("c16_pop_valid", 32'(instr_valid), 32'd0);

        // 32-bit instruction split over two pushes
        step(1'b1, 16'h0513, 1'b0);
        chk("i32_half_valid", 32'(instr_valid), 32'd0);
        chk("i32_half_instr", instr, 32'h0000_0513);
        step(1'b1, 16'h0010, 1'b0);
        chk("i32_valid", 32'(instr_valid), 32'd1);
        chk("i32_instr", instr, 32'h0010_0513);
        step(1'b0, 16'h0, 1'b1);
        chk("i32_pop_pc", 32'(instr_pc), 32'h6);
        chk("i32_pop_count", 32'(hw_count), 32'd0);

        // Fill to full, then stream through a pointer wrap
        step(1'b1, 16'h4505, 1'b0);
        step(1'b1, 16'h4509, 1'b0);
        step(1'b1, 16'h450d, 1'b0);
        step(1'b1, 16'h4511, 1'b0);
        chk("full_count", 32'(hw_count), 32'd4);
        chk("full_ready", 32'(mem_ready), 32'd0);
        chk("full_instr", instr, 32'h4509_4505);
        step(1'b1, 16'hffff, 1'b0);
        chk("full_no_take_count", 32'(hw_count), 32'd4);
        chk("full_no_take_instr", instr, 32'h4509_4505);
        drive(1'b1, 16'h4515, 1'b1);
        #1 chk("full_pop_ready", 32'(mem_ready), 32'd0);
        tick();
        chk("full_pop_count", 32'(hw_count), 32'd3);
        chk("full_pop_pc", 32'(instr_pc), 32'h8);
        chk("full_pop_instr", instr, 32'h450d_4509);
        chk("ready_again", 32'(mem_ready), 32'd1);
        step(1'b1, 16'h4515, 1'b1);
        chk("wrap1_count", 32'(hw_count), 32'd3);
        chk("wrap1_pc", 32'(instr_pc), 32'ha);
        chk("wrap1_instr", instr, 32'h4511_450d);
        step(1'b1, 16'h4519, 1'b1);
        chk("wrap2_count", 32'(hw_count), 32'd3);
        chk("wrap2_pc", 32'(instr_pc), 32'hc);
        chk("wrap2_instr", instr, 32'h4515_4511);
        step(1'b0, 16'h0, 1'b1);
        chk("drain_count", 32'(hw_count), 32'd2);
        chk("drain_instr", instr, 32'h4519_4515);

        // Push with pop at hw_count=2
        step(1'b1, 16'h0593, 1'b1);
        chk("pp16_count", 32'(hw_count), 32'd2);
        chk("pp16_pc", 32'(instr_pc), 32'h10);
        chk("pp16_instr", instr, 32'h0593_4519);
        step(1'b1, 16'h0020, 1'b1);
        chk("pp16b_count", 32'(hw_count), 32'd2);
        chk("pp16b_instr", instr, 32'h0020_0593);
        chk("pp16b_valid", 32'(instr_valid), 32'd1);
        step(1'b1, 16'h4501, 1'b1);
        chk("pp32_count", 32'(hw_count), 32'd1);
        chk("pp32_pc", 32'(instr_pc), 32'h16);
        chk("pp32_instr", instr, 32'h0000_4501);

        // Flush with three halfwords queued
        step(1'b1, 16'h1111, 1'b0);
        step(1'b1, 16'h2222, 1'b0);
        chk("pre_flush_count", 32'(hw_count), 32'd3);
        flush      = 1'b1;
        flush_addr = 24'h000103;
        drive(1'b1, 16'h9999, 1'b1);
        #1;
        chk("flush_restart", 32'(fetch_restart), 32'd1);
        chk("flush_addr_out", 32'(fetch_addr), 32'h102);
        chk("flush_ready", 32'(mem_ready), 32'd0);
        chk("flush_cycle_valid", 32'(instr_valid), 32'd1);
        tick();
        chk("post_flush_count", 32'(hw_count), 32'd0);
        chk("post_flush_valid", 32'(instr_valid), 32'd0);
        chk("post_flush_pc", 32'(instr_pc), 32'h102);
        chk("post_flush_restart", 32'(fetch_restart), 32'd0);
        chk("post_flush_instr", instr, 32'h0);
        step(1'b1, 16'h8082, 1'b0);
        chk("new_stream_instr", instr, 32'h0000_8082);
        chk("new_stream_pc", 32'(instr_pc), 32'h102);
        step(1'b0, 16'h0, 1'b1);
        chk("new_stream_pop_pc", 32'(instr_pc), 32'h104);

        // Reset mid-stream takes effect without a clock edge
        step(1'b1, 16'h0513, 1'b0);
        chk("pre_reset_count", 32'(hw_count), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_count", 32'(hw_count), 32'd0);
        chk("async_rst_pc", 32'(instr_pc), 32'h0);
        chk("async_rst_valid", 32'(instr_valid), 32'd0);
        chk("async_rst_instr", instr, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

`ifdef TINYQV_INSTR_BYPASS_EN
        drive(1'b1, 16'h8082, 1'b1);
        #1;
        chk("byp_valid", 32'(instr_valid), 32'd1);
        chk("byp_instr", instr, 32'h0000_8082);
        tick();
        chk("byp_count", 32'(hw_count), 32'd0);
        chk("byp_pc", 32'(instr_pc), 32'h2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
